// File: rtl/period_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : period_generator
//  Purpose  : Programmable-period square-wave generator. New periods are
//             double-buffered and take effect only on a period boundary, so
//             the output never shows a runt or glitch cycle.
//  Ports    : clk          in   system clock
//             reset        in   synchronous active-high reset
//             enable       in   1 = run, 0 = stop on the next edge
//             period_in    in   requested period in clk cycles (0 = stop)
//             period_load  in   strobe: capture period_in into pending
//             high_in      in   requested high time (DUTY_CTRL_EN only)
//             sig_out      out  registered square wave
//             rise_edge    out  pulse in the first high cycle of a period
//             load_ack     out  pulse in the cycle a new period takes effect
//             period_cur   out  period currently applied
//             running      out  1 while in RUN
//  Config   : DUTY_CTRL_EN  adds high_in; high time = high_in clamped to
//                           [1, P-1]. Otherwise high time = P>>1.
//  Revision : 1.0  initial release
// ============================================================================
module period_generator #(
  parameter int WIDTH      = 24,
  parameter int MIN_PERIOD = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] period_in,
  input  logic             period_load,
`ifdef DUTY_CTRL_EN
  input  logic [WIDTH-1:0] high_in,
`endif
  output logic             sig_out,
  output logic             rise_edge,
  output logic             load_ack,
  output logic [WIDTH-1:0] period_cur,
  output logic             running
);

  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] pending;
  logic             pending_valid;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] p_minus1;
  logic [WIDTH-1:0] count_inc;
  logic [WIDTH-1:0] high_eff;
  logic [WIDTH-1:0] next_p;
  logic [WIDTH-1:0] idle_p;
  logic             at_boundary;
  logic             boundary_apply;

`ifdef DUTY_CTRL_EN
  logic [WIDTH-1:0] high_cur;
  logic [WIDTH-1:0] high_pending;
  logic [WIDTH-1:0] next_h;
`endif

  // Zero is a stop request and passes through; small nonzero requests are
  // raised to MIN_PERIOD so the wave always has a high and a low cycle.
  assign load_val = (period_in == '0)  ? '0    :
                    (period_in < MIN_P) ? MIN_P : period_in;

  assign p_minus1    = period_cur - ONE;
  assign count_inc   = count + ONE;
  assign at_boundary = (count == p_minus1);

`ifdef DUTY_CTRL_EN
  assign high_eff = (high_cur == '0)      ? ONE      :
                    (high_cur > p_minus1) ? p_minus1 : high_cur;
`else
  assign high_eff = period_cur >> 1;
`endif

  // A load strobe landing on the boundary cycle wins over the pending
  // register, so it is applied at that very boundary.
  assign boundary_apply = period_load || pending_valid;

  always_comb begin
    next_p = period_cur;
`ifdef DUTY_CTRL_EN
    next_h = high_cur;
`endif
    if (period_load) begin
      next_p = load_val;
`ifdef DUTY_CTRL_EN
      next_h = high_in;
`endif
    end else if (pending_valid) begin
      next_p = pending;
`ifdef DUTY_CTRL_EN
      next_h = high_pending;
`endif
    end
  end

  assign idle_p  = pending_valid ? pending : period_cur;
  assign running = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= '0;
      pending       <= '0;
      pending_valid <= 1'b0;
      period_cur    <= '0;
      sig_out       <= 1'b0;
      rise_edge     <= 1'b0;
      load_ack      <= 1'b0;
`ifdef DUTY_CTRL_EN
      high_cur      <= '0;
      high_pending  <= '0;
`endif
    end else begin
      rise_edge <= 1'b0;
      load_ack  <= 1'b0;

      // Default capture into the pending register; the boundary branch
      // below overrides pending_valid when it consumes the strobe directly.
      if (period_load) begin
        pending       <= load_val;
        pending_valid <= 1'b1;
`ifdef DUTY_CTRL_EN
        high_pending  <= high_in;
`endif
      end

      case (state)
        S_IDLE: begin
          sig_out <= 1'b0;
          count   <= '0;
          if (pending_valid) begin
            period_cur <= pending;
            load_ack   <= 1'b1;
`ifdef DUTY_CTRL_EN
            high_cur   <= high_pending;
`endif
            if (!period_load) begin
              pending_valid <= 1'b0;
            end
          end
          // Any applied period is at least MIN_PERIOD, so the high time is
          // at least one cycle and the first RUN cycle is always high.
          if (enable && (idle_p != '0)) begin
            state     <= S_RUN;
            sig_out   <= 1'b1;
            rise_edge <= 1'b1;
          end
        end

        S_RUN: begin
          if (!enable) begin
            state   <= S_IDLE;
            sig_out <= 1'b0;
            count   <= '0;
          end else if (at_boundary) begin
            count <= '0;
            if (boundary_apply) begin
              period_cur    <= next_p;
              load_ack      <= 1'b1;
              pending_valid <= 1'b0;
`ifdef DUTY_CTRL_EN
              high_cur      <= next_h;
`endif
            end
            if (next_p == '0) begin
              state   <= S_IDLE;
              sig_out <= 1'b0;
            end else begin
              sig_out   <= 1'b1;
              rise_edge <= 1'b1;
            end
          end else begin
            count   <= count_inc;
            sig_out <= (count_inc < high_eff);
          end
        end

        default: begin
          state   <= S_IDLE;
          sig_out <= 1'b0;
          count   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_period_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_period_generator
//  Purpose  : Self-checking bench for period_generator. Expected per-cycle
//             {sig_out, rise_edge, load_ack} triples are queued as stimulus
//             is planned and popped as the DUT runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_period_generator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [W-1:0] period_in;
  logic         period_load;
  logic         sig_out;
  logic         rise_edge;
  logic         load_ack;
  logic [W-1:0] period_cur;
  logic         running;

`ifdef DUTY_CTRL_EN
  logic         duty_mode = 1'b0;
  logic [W-1:0] duty_val  = '0;
  logic [W-1:0] high_in;
  // Outside the duty test, request the symmetric high time.
  assign high_in = duty_mode ? duty_val : (period_in >> 1);
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic sig;
    logic rise;
    logic ack;
  } exp_t;

  exp_t sb[$];

  period_generator #(.WIDTH(W), .MIN_PERIOD(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .period_in   (period_in),
    .period_load (period_load),
`ifdef DUTY_CTRL_EN
    .high_in     (high_in),
`endif
    .sig_out     (sig_out),
    .rise_edge   (rise_edge),
    .load_ack    (load_ack),
    .period_cur  (period_cur),
    .running     (running)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full period of expected output: high for h cycles, rise at count 0.
  function automatic void push_period(int p, int h, bit ack);
    exp_t e;
    for (int c = 0; c < p; c++) begin
      e.sig  = (c < h);
      e.rise = (c == 0);
      e.ack  = ack && (c == 0);
      sb.push_back(e);
    end
  endfunction

  // Scoreboard consumer: compare the current cycle, then advance one clock.
  task automatic drain(int n, string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL %s[%0d]: scoreboard empty, got {sig,rise,ack}=%b",
                 tag, i, {sig_out, rise_edge, load_ack});
      end else begin
        e = sb.pop_front();
        if ({sig_out, rise_edge, load_ack} !== e) begin
          failures++;
          $display("FAIL %s[%0d]: got {sig,rise,ack}=%b want %b",
                   tag, i, {sig_out, rise_edge, load_ack}, e);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; period_load = 1'b0; period_in = '0;
    tick(); tick();
    checks++;
    if ({sig_out, rise_edge, load_ack, running, period_cur} !== '0) begin
      failures++;
      $display("FAIL reset_state: got %b want 0",
               {sig_out, rise_edge, load_ack, running, period_cur});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({sig_out, running, period_cur} !== '0) begin
      failures++;
      $display("FAIL reset_idle: got %b want 0", {sig_out, running, period_cur});
    end
  endtask

  task automatic test_basic();
    period_in = 8'd10; period_load = 1'b1; enable = 1'b1;
    tick();
    period_load = 1'b0;
    checks++;
    if ({sig_out, load_ack, running} !== 3'b000) begin
      failures++;
      $display("FAIL basic_capture: got %b want 000", {sig_out, load_ack, running});
    end
    tick();
    checks++;
    if (period_cur !== 8'd10 || running !== 1'b1) begin
      failures++;
      $display("FAIL basic_apply: got period_cur=%0d running=%b want 10/1",
               period_cur, running);
    end
    push_period(10, 5, 1'b1);
    push_period(10, 5, 1'b0);
    drain(20, "basic");
  endtask

  task automatic test_reload();
    push_period(10, 5, 1'b0);
    drain(3, "reload_a");
    period_in = 8'd4; period_load = 1'b1;
    drain(1, "reload_b");
    period_load = 1'b0;
    checks++;
    if (period_cur !== 8'd10) begin
      failures++;
      $display("FAIL reload_hold: got period_cur=%0d want 10", period_cur);
    end
    drain(6, "reload_c");
    push_period(4, 2, 1'b1);
    push_period(4, 2, 1'b0);
    checks++;
    if (period_cur !== 8'd4) begin
      failures++;
      $display("FAIL reload_apply: got period_cur=%0d want 4", period_cur);
    end
    drain(8, "reload_d");
  endtask

  task automatic test_clamp_and_stop();
    push_period(4, 2, 1'b0);
    period_in = 8'd1; period_load = 1'b1;
    drain(1, "clamp_a");
    period_load = 1'b0;
    drain(3, "clamp_b");
    checks++;
    if (period_cur !== 8'd2) begin
      failures++;
      $display("FAIL clamp_min: got period_cur=%0d want 2", period_cur);
    end
    push_period(2, 1, 1'b1);
    push_period(2, 1, 1'b0);
    push_period(2, 1, 1'b0);
    drain(6, "clamp_run");
    push_period(2, 1, 1'b0);
    period_in = 8'd0; period_load = 1'b1;
    drain(1, "stop_a");
    period_load = 1'b0;
    drain(1, "stop_b");
    checks++;
    if ({sig_out, rise_edge, load_ack, running} !== 4'b0010 || period_cur !== '0) begin
      failures++;
      $display("FAIL stop_boundary: got {sig,rise,ack,run}=%b period_cur=%0d want 0010/0",
               {sig_out, rise_edge, load_ack, running}, period_cur);
    end
    tick();
    checks++;
    if ({sig_out, load_ack, running} !== 3'b000) begin
      failures++;
      $display("FAIL stop_idle: got %b want 000", {sig_out, load_ack, running});
    end
  endtask

  task automatic test_last_wins_and_bypass();
    period_in = 8'd10; period_load = 1'b1;
    tick();
    period_load = 1'b0;
    tick();
    push_period(10, 5, 1'b1);
    push_period(8, 4, 1'b1);
    push_period(8, 4, 1'b0);
    drain(2, "lw_a");
    period_in = 8'd6; period_load = 1'b1;
    drain(1, "lw_b");
    period_load = 1'b0;
    drain(2, "lw_c");
    period_in = 8'd8; period_load = 1'b1;
    drain(1, "lw_d");
    period_load = 1'b0;
    drain(4, "lw_e");
    checks++;
    if (period_cur !== 8'd8) begin
      failures++;
      $display("FAIL last_wins: got period_cur=%0d want 8", period_cur);
    end
    drain(8, "lw_f");
    drain(7, "lw_g");
    period_in = 8'd3; period_load = 1'b1;
    drain(1, "bypass_a");
    period_load = 1'b0;
    checks++;
    if (period_cur !== 8'd3) begin
      failures++;
      $display("FAIL bypass_apply: got period_cur=%0d want 3", period_cur);
    end
    push_period(3, 1, 1'b1);
    drain(3, "bypass_b");
  endtask

  task automatic test_enable_drop();
    enable = 1'b0;
    tick();
    checks++;
    if ({sig_out, rise_edge, running} !== 3'b000 || period_cur !== 8'd3) begin
      failures++;
      $display("FAIL enable_drop: got {sig,rise,run}=%b period_cur=%0d want 000/3",
               {sig_out, rise_edge, running}, period_cur);
    end
    tick(); tick();
    checks++;
    if ({sig_out, running} !== 2'b00) begin
      failures++;
      $display("FAIL enable_idle: got %b want 00", {sig_out, running});
    end
    enable = 1'b1;
    tick();
    checks++;
    if ({sig_out, rise_edge, running} !== 3'b111) begin
      failures++;
      $display("FAIL reenable: got {sig,rise,run}=%b want 111",
               {sig_out, rise_edge, running});
    end
    push_period(3, 1, 1'b0);
    drain(3, "reenable_run");
  endtask

  task automatic test_reset_mid();
    bit found;
    reset = 1'b1;
    tick();
    checks++;
    if ({sig_out, rise_edge, load_ack, running, period_cur} !== '0) begin
      failures++;
      $display("FAIL reset_mid: got %b want 0",
               {sig_out, rise_edge, load_ack, running, period_cur});
    end
    reset = 1'b0;
    tick();
    period_in = 8'd6; period_load = 1'b1;
    tick();
    period_load = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      if (load_ack === 1'b1) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_recover: load_ack=%b after 5 cycles want 1", load_ack);
    end else begin
      push_period(6, 3, 1'b1);
      drain(6, "reset_recover");
    end
  endtask

  task automatic test_max_period();
    push_period(6, 3, 1'b0);
    period_in = 8'd255; period_load = 1'b1;
    drain(1, "max_a");
    period_load = 1'b0;
    drain(5, "max_b");
    checks++;
    if (period_cur !== 8'd255) begin
      failures++;
      $display("FAIL max_apply: got period_cur=%0d want 255", period_cur);
    end
    push_period(255, 127, 1'b1);
    push_period(255, 127, 1'b0);
    drain(510, "max_run");
  endtask

`ifdef DUTY_CTRL_EN
  task automatic test_duty();
    enable = 1'b0;
    tick();
    duty_mode = 1'b1; duty_val = 8'd3;
    period_in = 8'd10; period_load = 1'b1;
    tick();
    period_load = 1'b0;
    tick();
    checks++;
    if (period_cur !== 8'd10 || running !== 1'b0) begin
      failures++;
      $display("FAIL duty_idle_apply: got period_cur=%0d running=%b want 10/0",
               period_cur, running);
    end
    enable = 1'b1;
    tick();
    push_period(10, 3, 1'b0);
    push_period(10, 3, 1'b0);
    drain(1, "duty3_a");
    duty_val = 8'd0; period_load = 1'b1;
    drain(1, "duty3_b");
    period_load = 1'b0;
    drain(18, "duty3_c");
    push_period(10, 1, 1'b1);
    drain(1, "duty0_a");
    duty_val = 8'd12; period_load = 1'b1;
    drain(1, "duty0_b");
    period_load = 1'b0;
    drain(8, "duty0_c");
    push_period(10, 9, 1'b1);
    drain(10, "duty12");
    duty_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_clamp_and_stop();
    test_last_wins_and_bypass();
    test_enable_drop();
    test_reset_mid();
    test_max_period();
`ifdef DUTY_CTRL_EN
    test_duty();
`endif
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: got %0d entries want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
